pipe_reg_chain: RTL and testbench

- Parametrised successor to the team's single load-enable register: a chain of STAGES data registers, each N bits wide, with valid/ready flow control, synchronous flush and an occupancy count.
- Used between datapath units that can stall, e.g. ALU result → writeback, so back-pressure never drops or duplicates data.
- Full throughput of one transfer per cycle when the output is not stalled.

---
 rtl/pipe_reg_chain_pkg.sv | 13 +
 rtl/pipe_reg_chain_stage.sv | 36 +++
 rtl/pipe_reg_chain.sv | 114 +++++++++++
 tb/tb_pipe_reg_chain.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the valid/ready register chain: default sizes and
// the occupancy-count width helper.
package pipe_reg_pkg;

  localparam int N_DEF      = 8;
  localparam int STAGES_DEF = 3;

  // Count must reach STAGES+1 when the skid entry is present.
  function automatic int cnt_width(input int stages);
    return $clog2(stages + 2);
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One valid/data stage of the chain. A stage loads whenever it is empty or
// its downstream neighbour is taking its current word.
module pipe_reg_stage
  import pipe_reg_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         up_valid,
  input  logic [N-1:0] up_data,
  input  logic         dn_ready,
  output logic         v,
  output logic [N-1:0] d,
  output logic         rdy
);

  assign rdy = ~v | dn_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
    end else begin
      if (flush)
        v <= 1'b0;
      else if (rdy)
        v <= up_valid;
      // Data only moves with a valid word so a held output never glitches.
      if (rdy && up_valid)
        d <= up_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of STAGES valid/ready register stages with flush and occupancy count.
// Optional macro PIPE_REG_CHAIN_SKID_EN adds a skid entry and registered in_ready.
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CW     = cnt_width(STAGES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  logic [STAGES-1:0] w_v;
  logic [N-1:0]      w_d [STAGES];
  logic              w_rdy0;
  logic              w_s0_valid;
  logic [N-1:0]      w_s0_data;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [CW-1:0]     r_count;

  // Each stage keeps its ready as a separate net; the ready chain runs
  // combinationally from out_ready back to stage 0.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         w_rdy;
    logic         w_dn;
    logic         w_up_valid;
    logic [N-1:0] w_up_data;

    if (k == STAGES - 1) begin : g_last
      assign w_dn = out_ready;
    end else begin : g_mid
      assign w_dn = g_stage[k+1].w_rdy;
    end

    if (k == 0) begin : g_first
      assign w_up_valid = w_s0_valid;
      assign w_up_data  = w_s0_data;
    end else begin : g_next
      assign w_up_valid = w_v[k-1];
      assign w_up_data  = w_d[k-1];
    end

    pipe_reg_stage #(.N(N)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (w_up_valid),
      .up_data  (w_up_data),
      .dn_ready (w_dn),
      .v        (w_v[k]),
      .d        (w_d[k]),
      .rdy      (w_rdy)
    );
  end

  assign w_rdy0 = g_stage[0].w_rdy;

`ifdef PIPE_REG_CHAIN_SKID_EN
  logic         r_skid_v;
  logic [N-1:0] r_skid_d;

  assign in_ready   = ~r_skid_v & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  // A parked word drains ahead of new input; otherwise input bypasses the skid.
  assign w_s0_valid = r_skid_v | w_in_xfer;
  assign w_s0_data  = r_skid_v ? r_skid_d : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_v <= 1'b0;
      r_skid_d <= '0;
    end else if (flush) begin
      r_skid_v <= 1'b0;
    end else if (r_skid_v) begin
      if (w_rdy0)
        r_skid_v <= 1'b0;
    end else if (w_in_xfer && !w_rdy0) begin
      r_skid_v <= 1'b1;
      r_skid_d <= in_data;
    end
  end
`else
  assign in_ready   = w_rdy0 & ~flush;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_s0_valid = w_in_xfer;
  assign w_s0_data  = in_data;
`endif

  assign out_valid  = w_v[STAGES-1];
  assign out_data   = w_d[STAGES-1];
  assign w_out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush)
      r_count <= '0;
    else if (w_in_xfer && !w_out_xfer)
      r_count <= r_count + CW'(1);
    else if (!w_in_xfer && w_out_xfer)
      r_count <= r_count - CW'(1);
  end

  assign count = r_count;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain against a queue-of-entries
// reference model; builds for either PIPE_REG_CHAIN_SKID_EN setting.
module tb_pipe_reg_chain;

  localparam int S = 3;
  localparam int N = 8;
`ifdef PIPE_REG_CHAIN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = S + (SKID ? 1 : 0);

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic [2:0]   count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.N(N), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: ordered list of held words, each with its position in the
  // chain (-1 = skid slot, S = delivered). A word advances one place per
  // cycle unless the place ahead stays occupied.
  typedef struct {
    logic [7:0] data;
    int         pos;
  } ent_t;

  ent_t q[$];
  int   newpos[$];
  bit   m_rdy0;

  function automatic void plan(input bit ordy);
    int ahead = ordy ? S + 1 : S;
    newpos.delete();
    for (int i = 0; i < q.size(); i++) begin
      int np = (q[i].pos + 1 < ahead) ? q[i].pos + 1 : q[i].pos;
      newpos.push_back(np);
      ahead = np;
    end
    m_rdy0 = (ahead > 0);
  endfunction

  task automatic cycle(input bit iv, input logic [7:0] id, input bit ordy,
                       input bit fl, input bit rst);
    bit   exp_ir;
    bit   exp_ov;
    ent_t e;
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #2;
    plan(ordy);
    if (SKID)
      exp_ir = !(q.size() > 0 && q[q.size()-1].pos < 0) && !fl;
    else
      exp_ir = m_rdy0 && !fl;
    exp_ov = (q.size() > 0 && q[0].pos == S - 1);
    check_val("in_ready", in_ready, exp_ir);
    check_val("out_valid", out_valid, exp_ov);
    if (exp_ov) check_val("out_data", out_data, q[0].data);
    check_val("count", count, q.size());
    if (rst || fl) begin
      q.delete();
    end else begin
      for (int i = 0; i < q.size(); i++) begin
        e = q[i];
        e.pos = newpos[i];
        q[i] = e;
      end
      if (q.size() > 0 && q[0].pos == S) void'(q.pop_front());
      if (iv && exp_ir) begin
        e.data = id;
        e.pos  = m_rdy0 ? 0 : -1;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and streaming
    cycle(0, 8'h00, 1, 0, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 8'h00);
    check_val("rst_count", count, 0);
    cycle(1, 8'h11, 1, 0, 0);
    cycle(1, 8'h22, 1, 0, 0);
    cycle(1, 8'h33, 1, 0, 0);
    check_val("s1_first_valid", out_valid, 1);
    check_val("s1_first_data", out_data, 8'h11);
    check_val("s1_count", count, 3);
    cycle(1, 8'h44, 1, 0, 0);
    check_val("s1_second_data", out_data, 8'h22);
    check_val("s1_count_steady", count, 3);
    repeat (4) cycle(0, 8'h00, 1, 0, 0);

    // Fill under stall, then hold
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'hA0, 0, 0, 0);
    cycle(1, 8'hA1, 0, 0, 0);
    cycle(1, 8'hA2, 0, 0, 0);
    cycle(1, 8'hA3, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'hA3, 0, 0, 0);
      check_val("s2_hold_data", out_data, 8'hA0);
    end
    check_val("s2_count_full", count, CAP);
    check_val("s2_in_ready", in_ready, 0);

    // Simultaneous in/out on a full chain
    cycle(1, 8'h55, 1, 0, 0);
    check_val("s3_next_data", out_data, 8'hA1);
    check_val("s3_count", count, 3);
    repeat (6) cycle(0, 8'h00, 1, 0, 0);

    // Bubble collapse under stall
    cycle(0, 8'h00, 0, 0, 1);
    cycle(1, 8'h02, 0, 0, 0);
    cycle(1, 8'h01, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 0);
    check_val("s4_out_valid", out_valid, 1);
    check_val("s4_out_data", out_data, 8'h02);
    check_val("s4_count", count, 2);

    // Flush with two entries held and input offered
    cycle(1, 8'h77, 0, 1, 0);
    check_val("s5_count", count, 0);
    check_val("s5_out_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check_val("s5_in_ready_after", in_ready, 1);
    cycle(0, 8'h00, 1, 0, 0);

    // Reset mid-stream
    cycle(1, 8'h31, 0, 0, 0);
    cycle(1, 8'h32, 0, 0, 0);
    cycle(1, 8'h33, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1);
    check_val("s6_out_valid", out_valid, 0);
    check_val("s6_out_data", out_data, 8'h00);
    check_val("s6_count", count, 0);
    cycle(1, 8'h99, 1, 0, 0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      cycle(0, 8'h00, 1, 0, 0);
      lat++;
    end
    check_val("s6_latency", lat, 3);
    check_val("s6_data", out_data, 8'h99);

    // Random traffic: light then heavy back-pressure
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 500; i++) begin
        int r = $urandom_range(0, 199);
        cycle($urandom_range(0, 3) != 0, 8'($urandom()),
              (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) < 3),
              (r >= 2 && r < 6), (r < 2));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
